// File: rtl/ifetch_buffer_if.sv
// Fetch-side bundle for ifetch_buffer: memory request/response, redirect and
// decode handshake. The master modport is the fetch buffer itself.
interface ifetch_buffer_if;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [31:0] o_mem_req_addr;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rsp_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_trap;

  modport master (
    output o_mem_req_valid,
    output o_mem_req_addr,
    input  i_mem_req_ready,
    input  i_mem_rsp_valid,
    input  i_mem_rsp_data,
    input  i_redirect,
    input  i_redirect_pc,
    output o_inst_valid,
    output o_inst,
    output o_inst_pc,
    output o_inst_trap,
    input  i_inst_ready
  );

  modport slave (
    input  o_mem_req_valid,
    input  o_mem_req_addr,
    output i_mem_req_ready,
    output i_mem_rsp_valid,
    output i_mem_rsp_data,
    output i_redirect,
    output i_redirect_pc,
    input  o_inst_valid,
    input  o_inst,
    input  o_inst_pc,
    input  o_inst_trap,
    output i_inst_ready
  );
endinterface

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: issues sequential word fetches, queues in-order
// responses with their PCs, and handles redirects and misaligned-target traps.
module ifetch_buffer #(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ifetch_buffer_if.master bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        trap;
  } entry_t;

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [TW-1:0] tag_rd;
  logic [TW-1:0] tag_wr;

  entry_t        q      [DEPTH];
  logic [31:0]   tag_pc [MAX_OUTSTANDING];

  logic   req_valid;
  logic   accept;
  logic   rsp;
  logic   keep;
  logic   pop;
  logic   redirect;
  logic   trap_redirect;
  entry_t head_e;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    if (32'(p) == MAX_OUTSTANDING - 1) begin
      return '0;
    end
    return p + TW'(1);
  endfunction

  // Issue is held back so every in-flight response is guaranteed a queue slot.
  always_comb begin
    req_valid = 1'b0;
    if (!i_rst && !bus.i_redirect && state == ST_RUN &&
        (32'(outstanding) < MAX_OUTSTANDING) &&
        (32'(outstanding) + 32'(count) < DEPTH)) begin
      req_valid = 1'b1;
    end
  end

  assign redirect      = bus.i_redirect;
  assign trap_redirect = bus.i_redirect && (bus.i_redirect_pc[1:0] != 2'b00);
  assign accept        = req_valid && bus.i_mem_req_ready;
  assign rsp           = bus.i_mem_rsp_valid;
  assign keep          = rsp && (drop_cnt == '0) && !redirect;
  assign pop           = (count != '0) && bus.i_inst_ready && !redirect;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_RUN;
      pc          <= RESET_ADDR;
      outstanding <= '0;
      drop_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
    end else begin
      // The tag FIFO advances on every response, kept or dropped, so it always
      // lines up with the oldest in-flight request and needs no flush.
      if (accept) begin
        tag_wr <= tag_next(tag_wr);
      end
      if (rsp) begin
        tag_rd <= tag_next(tag_rd);
      end
      outstanding <= outstanding + OW'(accept) - OW'(rsp);

      if (redirect) begin
        pc       <= bus.i_redirect_pc;
        drop_cnt <= outstanding - OW'(rsp);
        head     <= '0;
        if (trap_redirect) begin
          tail  <= PW'(1);
          count <= CW'(1);
          state <= ST_HALTED;
        end else begin
          tail  <= '0;
          count <= '0;
          state <= ST_RUN;
        end
      end else begin
        if (accept) begin
          pc <= pc + 32'd4;
        end
        if (rsp && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - OW'(1);
        end
        if (keep) begin
          tail <= tail + PW'(1);
        end
        if (pop) begin
          head <= head + PW'(1);
        end
        count <= count + CW'(keep) - CW'(pop);
      end
    end
  end

  // Data storage carries no reset; occupancy and pointers gate every read.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      tag_pc[tag_wr] <= pc;
    end
    if (trap_redirect) begin
      q[0] <= '{inst: '0, pc: bus.i_redirect_pc, trap: 1'b1};
    end else if (keep) begin
      q[tail] <= '{inst: bus.i_mem_rsp_data, pc: tag_pc[tag_rd], trap: 1'b0};
    end
  end

  assign head_e = q[head];

  assign bus.o_mem_req_valid = req_valid;
  assign bus.o_mem_req_addr  = i_rst ? '0 : pc;
  assign bus.o_inst_valid    = (count != '0);
  assign bus.o_inst          = (count != '0) ? head_e.inst : '0;
  assign bus.o_inst_pc       = (count != '0) ? head_e.pc   : '0;
  assign bus.o_inst_trap     = (count != '0) ? head_e.trap : 1'b0;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer with a 1- or 2-cycle latency memory model.
module tb_ifetch_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifetch_buffer_if bus();

  ifetch_buffer #(
    .RESET_ADDR     (32'h0000_0000),
    .DEPTH          (4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic        lat2 = 1'b0;
  logic        s1v, s2v;
  logic [31:0] s1d, s2d;
  logic [31:0] acc_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];
  logic        pop_trap[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: in-order responses after 1 or 2 cycles, cleared with the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1v <= 1'b0; s2v <= 1'b0; s1d <= '0; s2d <= '0;
    end else begin
      s1v <= bus.o_mem_req_valid && bus.i_mem_req_ready;
      s1d <= memf(bus.o_mem_req_addr);
      s2v <= s1v;
      s2d <= s1d;
    end
  end
  assign bus.i_mem_rsp_valid = lat2 ? s2v : s1v;
  assign bus.i_mem_rsp_data  = lat2 ? s2d : s1d;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.o_mem_req_valid && bus.i_mem_req_ready) acc_log.push_back(bus.o_mem_req_addr);
      if (bus.o_inst_valid && bus.i_inst_ready && !bus.i_redirect) begin
        pop_pc.push_back(bus.o_inst_pc);
        pop_inst.push_back(bus.o_inst);
        pop_trap.push_back(bus.o_inst_trap);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete(); pop_pc.delete(); pop_inst.delete(); pop_trap.delete();
  endtask

  task automatic do_reset(input logic l2, input logic irdy);
    rst = 1'b1;
    lat2 = l2;
    bus.i_mem_req_ready = 1'b1;
    bus.i_inst_ready    = irdy;
    bus.i_redirect      = 1'b0;
    bus.i_redirect_pc   = '0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst = 1'b0;
  endtask

  initial begin
    int stale;
    bus.i_mem_req_ready = 1'b1;
    bus.i_inst_ready    = 1'b1;
    bus.i_redirect      = 1'b0;
    bus.i_redirect_pc   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(bus.o_mem_req_valid), 0);
    check("rst_req_addr",  bus.o_mem_req_addr, 0);
    check("rst_inst_valid", 32'(bus.o_inst_valid), 0);
    check("rst_inst", bus.o_inst, 0);
    check("rst_inst_pc", bus.o_inst_pc, 0);
    check("rst_inst_trap", 32'(bus.o_inst_trap), 0);

    // Streaming fetch, 1-cycle latency
    do_reset(1'b0, 1'b1);
    #1;
    check("t1_first_valid", 32'(bus.o_mem_req_valid), 1);
    check("t1_first_addr", bus.o_mem_req_addr, 32'h0);
    repeat (10) @(negedge clk);
    check("t1_nacc", acc_log.size(), 10);
    check("t1_npop", pop_pc.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_acc%0d", i), acc_log[i], 32'(4 * i));
      check($sformatf("t1_pc%0d", i), pop_pc[i], 32'(4 * i));
      check($sformatf("t1_inst%0d", i), pop_inst[i], memf(32'(4 * i)));
    end

    // Decode stalled: queue fills to DEPTH then fetch stops
    do_reset(1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    check("t2_nacc", acc_log.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_acc%0d", i), acc_log[i], 32'(4 * i));
    check("t2_req_valid", 32'(bus.o_mem_req_valid), 0);
    check("t2_inst_valid", 32'(bus.o_inst_valid), 1);
    check("t2_head_pc", bus.o_inst_pc, 32'h0);
    clear_logs();
    bus.i_inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("t2_npop_ge6", 32'(pop_pc.size() >= 6), 1);
    for (int i = 0; i < 6; i++) check($sformatf("t2_pc%0d", i), pop_pc[i], 32'(4 * i));
    check("t2_resume_addr", acc_log[0], 32'h10);

    // Redirect with two requests in flight
    do_reset(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    clear_logs();
    bus.i_redirect = 1'b1;
    bus.i_redirect_pc = 32'h100;
    @(negedge clk);
    bus.i_redirect = 1'b0;
    repeat (8) @(negedge clk);
    check("t3_npop_ge2", 32'(pop_pc.size() >= 2), 1);
    check("t3_pc0", pop_pc[0], 32'h100);
    check("t3_inst0", pop_inst[0], memf(32'h100));
    check("t3_pc1", pop_pc[1], 32'h104);
    check("t3_acc0", acc_log[0], 32'h100);
    stale = 0;
    foreach (pop_pc[i]) if (pop_pc[i] < 32'h100) stale++;
    check("t3_stale", stale, 0);

    // Misaligned redirect: trap entry, halt, then recover
    do_reset(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus.i_redirect = 1'b1;
    bus.i_redirect_pc = 32'h102;
    @(negedge clk);
    bus.i_redirect = 1'b0;
    #1;
    check("t4_trap_valid", 32'(bus.o_inst_valid), 1);
    check("t4_trap_pc", bus.o_inst_pc, 32'h102);
    check("t4_trap_inst", bus.o_inst, 32'h0);
    check("t4_trap_flag", 32'(bus.o_inst_trap), 1);
    check("t4_halt_req", 32'(bus.o_mem_req_valid), 0);
    clear_logs();
    repeat (4) @(negedge clk);
    check("t4_halt_nacc", acc_log.size(), 0);
    check("t4_halt_req2", 32'(bus.o_mem_req_valid), 0);
    check("t4_head_held", bus.o_inst_pc, 32'h102);
    bus.i_inst_ready = 1'b1;
    @(negedge clk);
    bus.i_inst_ready = 1'b0;
    #1;
    check("t4_npop", pop_pc.size(), 1);
    check("t4_pop_trap", 32'(pop_trap[0]), 1);
    check("t4_pop_pc", pop_pc[0], 32'h102);
    check("t4_empty", 32'(bus.o_inst_valid), 0);
    clear_logs();
    bus.i_redirect = 1'b1;
    bus.i_redirect_pc = 32'h200;
    @(negedge clk);
    bus.i_redirect = 1'b0;
    bus.i_inst_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_resume_acc", acc_log[0], 32'h200);
    check("t4_resume_pc", pop_pc[0], 32'h200);
    check("t4_resume_trap", 32'(pop_trap[0]), 0);
    check("t4_resume_inst", pop_inst[0], memf(32'h200));

    // Memory backpressure with address 0x8 pending
    do_reset(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    bus.i_mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t5_valid%0d", i), 32'(bus.o_mem_req_valid), 1);
      check($sformatf("t5_addr%0d", i), bus.o_mem_req_addr, 32'h8);
      @(negedge clk);
    end
    bus.i_mem_req_ready = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("t5_acc%0d", i), acc_log[i], 32'(4 * i));

    // Reset pulse with two requests outstanding
    do_reset(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    check("t6_pre_valid", 32'(bus.o_inst_valid), 1);
    check("t6_pre_pc", bus.o_inst_pc, 32'h0);
    rst = 1'b1;
    #1;
    check("t6_rst_req_valid", 32'(bus.o_mem_req_valid), 0);
    check("t6_rst_addr", bus.o_mem_req_addr, 32'h0);
    check("t6_rst_inst_valid", 32'(bus.o_inst_valid), 0);
    check("t6_rst_inst_pc", bus.o_inst_pc, 32'h0);
    repeat (2) @(negedge clk);
    clear_logs();
    rst = 1'b0;
    #1;
    check("t6_restart_valid", 32'(bus.o_mem_req_valid), 1);
    check("t6_restart_addr", bus.o_mem_req_addr, 32'h0);
    bus.i_inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("t6_acc0", acc_log[0], 32'h0);
    check("t6_pc0", pop_pc[0], 32'h0);
    check("t6_inst0", pop_inst[0], memf(32'h0));
    check("t6_pc1", pop_pc[1], 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
